// File: rtl/mem_addr_arbiter.sv
// mem_addr_arbiter
//   Shares one memory port between instruction fetch and load/store.
//   Grants one requester at a time, registers the address-mux select and
//   write enable at grant, and runs a req/ack handshake with memory.
//   Data normally wins a collision; after STARVE_MAX consecutive data
//   grants taken while fetch was waiting, fetch is forced through.
//
//   Optional build macro: MEM_ARB_TIMEOUT_EN
//     defined   -> watchdog aborts an access after TIMEOUT_CYCLES cycles
//                  without i_mem_ack (o_timeout + owner's done pulse)
//     undefined -> waits for ack indefinitely, o_timeout tied low
//
// Ports
//   i_clk, i_arst        clock (rising), async active-high reset
//   i_fetch_req          fetch request (level)
//   o_fetch_done         fetch complete, 1-cycle pulse
//   i_data_req           load/store request (level)
//   i_data_we            1 = store, sampled at data grant
//   o_data_done          data access complete, 1-cycle pulse
//   o_addr_sel           address mux select: 0 fetch, 1 data
//   o_mem_req            memory request, held until ack
//   o_mem_we             memory write enable, valid with o_mem_req
//   i_mem_ack            memory completion pulse
//   o_busy               access in progress
//   o_timeout            access aborted by watchdog, 1-cycle pulse
//
// state | meaning
// IDLE  | no access in flight, arbitrate requests
// FETCH | fetch access waiting for ack
// DATA  | load/store access waiting for ack

module mem_addr_arbiter #(
  parameter int STARVE_MAX     = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_arst,
  input  logic i_fetch_req,
  output logic o_fetch_done,
  input  logic i_data_req,
  input  logic i_data_we,
  output logic o_data_done,
  output logic o_addr_sel,
  output logic o_mem_req,
  output logic o_mem_we,
  input  logic i_mem_ack,
  output logic o_busy,
  output logic o_timeout
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       we_q, we_d;
  logic       sel_q, sel_d;
  logic       tmo_hit;
  logic       fetch_forced;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q;

  // Held at zero in IDLE, so every grant starts counting from the first
  // access cycle; the count reaches TMO_LAST on the TIMEOUT_CYCLES-th
  // cycle without ack.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst)
      tmo_cnt_q <= '0;
    else if (state_q == IDLE)
      tmo_cnt_q <= '0;
    else if (!i_mem_ack)
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
  end

  assign tmo_hit = (state_q != IDLE) && (tmo_cnt_q == TMO_LAST);
`else
  // Watchdog not built; the expression is constant 0.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  assign fetch_forced = i_fetch_req && (starve_q == STARVE_LIM);
  assign o_addr_sel   = sel_q;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      we_q     <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    we_d         = we_q;
    sel_d        = sel_q;
    o_mem_req    = 1'b0;
    o_busy       = 1'b0;
    o_mem_we     = 1'b0;
    o_fetch_done = 1'b0;
    o_data_done  = 1'b0;
    o_timeout    = 1'b0;

    case (state_q)
      IDLE: begin
        // Ack in IDLE is ignored. Select holds between accesses.
        if (i_data_req && !fetch_forced) begin
          state_d = DATA;
          sel_d   = 1'b1;
          we_d    = i_data_we;
          if (i_fetch_req && (starve_q != STARVE_LIM))
            starve_d = starve_q + 4'd1;
        end else if (i_fetch_req) begin
          state_d  = FETCH;
          sel_d    = 1'b0;
          we_d     = 1'b0;
          starve_d = '0;
        end
      end
      FETCH: begin
        o_mem_req = 1'b1;
        o_busy    = 1'b1;
        if (i_mem_ack || tmo_hit) begin
          o_fetch_done = 1'b1;
          o_timeout    = !i_mem_ack;
          state_d      = IDLE;
        end
      end
      DATA: begin
        o_mem_req = 1'b1;
        o_busy    = 1'b1;
        o_mem_we  = we_q;
        if (i_mem_ack || tmo_hit) begin
          o_data_done = 1'b1;
          o_timeout   = !i_mem_ack;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_addr_arbiter.sv
module tb_mem_addr_arbiter;

  localparam int TMO = 64;

  logic i_clk = 1'b0;
  logic i_arst;
  logic i_fetch_req, i_data_req, i_data_we, i_mem_ack;
  logic o_fetch_done, o_data_done, o_addr_sel, o_mem_req, o_mem_we;
  logic o_busy, o_timeout;

  typedef struct packed {
    logic sel;
    logic we;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_addr_arbiter #(.STARVE_MAX(3), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk       (i_clk),
    .i_arst      (i_arst),
    .i_fetch_req (i_fetch_req),
    .o_fetch_done(o_fetch_done),
    .i_data_req  (i_data_req),
    .i_data_we   (i_data_we),
    .o_data_done (o_data_done),
    .o_addr_sel  (o_addr_sel),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .i_mem_ack   (i_mem_ack),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic sel, input logic we);
    exp_t e;
    e.sel = sel;
    e.we  = we;
    sb.push_back(e);
  endtask

  // Waits (bounded) for o_mem_req, then pops the expected grant and
  // compares the registered select and write enable.
  task automatic wait_grant(input string tag, output exp_t e);
    e = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_mem_req) break;
    end
    chk({tag, "_grant_seen"}, o_mem_req, 1);
    chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    if (!o_mem_req || sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_addr_sel"}, o_addr_sel, e.sel);
    chk({tag, "_mem_we"}, o_mem_we, e.we);
    chk({tag, "_busy"}, o_busy, 1);
  endtask

  // Called at the negedge of the first access cycle; acks in cycle lat.
  task automatic run_access(input string tag, input int lat, input exp_t e);
    for (int i = 1; i < lat; i++) begin
      chk({tag, "_req_held"}, o_mem_req, 1);
      chk({tag, "_we_held"}, o_mem_we, e.we);
      chk({tag, "_no_done"}, {o_fetch_done, o_data_done}, 0);
      @(negedge i_clk);
    end
    i_mem_ack = 1'b1;
    #1;
    chk({tag, "_fetch_done"}, o_fetch_done, !e.sel);
    chk({tag, "_data_done"}, o_data_done, e.sel);
    chk({tag, "_no_timeout"}, o_timeout, 0);
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    chk({tag, "_req_drop"}, o_mem_req, 0);
    chk({tag, "_idle"}, o_busy, 0);
  endtask

  initial begin
    i_arst = 1'b1;
    i_fetch_req = 1'b0;
    i_data_req  = 1'b0;
    i_data_we   = 1'b0;
    i_mem_ack   = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_outputs", {o_fetch_done, o_data_done, o_addr_sel, o_mem_req,
                        o_mem_we, o_busy, o_timeout}, 0);
    i_arst = 1'b0;
    @(negedge i_clk);
    chk("post_rst_idle", o_busy, 0);

    // fetch only, ack 3 cycles after grant
    push(1'b0, 1'b0);
    i_fetch_req = 1'b1;
    wait_grant("fetch", cur);
    run_access("fetch", 3, cur);
    i_fetch_req = 1'b0;
    @(negedge i_clk);
    chk("fetch_no_regrant", o_mem_req, 0);

    // collision: data wins as a store, then fetch
    push(1'b1, 1'b1);
    push(1'b0, 1'b0);
    i_fetch_req = 1'b1;
    i_data_req  = 1'b1;
    i_data_we   = 1'b1;
    wait_grant("coll_data", cur);
    run_access("coll_data", 2, cur);
    chk("coll_sel_hold", o_addr_sel, 1);
    i_data_req = 1'b0;
    i_data_we  = 1'b0;
    wait_grant("coll_fetch", cur);
    run_access("coll_fetch", 1, cur);
    i_fetch_req = 1'b0;
    @(negedge i_clk);
    chk("coll_sel_hold_fetch", o_addr_sel, 0);

    // starvation: D,D,D, pause with spurious ack, then F,D,D,D,F
    push(1'b1, 1'b0); push(1'b1, 1'b0); push(1'b1, 1'b0);
    push(1'b0, 1'b0);
    push(1'b1, 1'b0); push(1'b1, 1'b0); push(1'b1, 1'b0);
    push(1'b0, 1'b0);
    i_fetch_req = 1'b1;
    i_data_req  = 1'b1;
    for (int g = 0; g < 3; g++) begin
      wait_grant("starve_a", cur);
      run_access("starve_a", 1, cur);
    end
    i_fetch_req = 1'b0;
    i_data_req  = 1'b0;
    @(negedge i_clk);
    i_mem_ack = 1'b1;
    #1;
    chk("spurious_no_done", {o_fetch_done, o_data_done}, 0);
    chk("spurious_no_req", o_mem_req, 0);
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    chk("spurious_idle", o_busy, 0);
    i_fetch_req = 1'b1;
    i_data_req  = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_grant("starve_b", cur);
      run_access("starve_b", 1, cur);
    end
    i_fetch_req = 1'b0;
    i_data_req  = 1'b0;
    @(negedge i_clk);

    // reset asserted mid-DATA
    push(1'b1, 1'b1);
    i_data_req = 1'b1;
    i_data_we  = 1'b1;
    wait_grant("rstmid", cur);
    i_arst = 1'b1;
    #1;
    chk("rstmid_req", o_mem_req, 0);
    chk("rstmid_sel", o_addr_sel, 0);
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_we", o_mem_we, 0);
    @(negedge i_clk);
    i_arst     = 1'b0;
    i_data_req = 1'b0;
    i_data_we  = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rstmid_idle", {o_mem_req, o_busy}, 0);

    // watchdog
    push(1'b1, 1'b0);
    i_data_req = 1'b1;
    wait_grant("wd", cur);
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 1; c < TMO; c++) begin
      chk("wd_no_timeout", o_timeout, 0);
      chk("wd_req_held", o_mem_req, 1);
      @(negedge i_clk);
    end
    chk("wd_timeout", o_timeout, 1);
    chk("wd_data_done", o_data_done, 1);
    @(negedge i_clk);
    i_data_req = 1'b0;
    chk("wd_idle", {o_mem_req, o_busy}, 0);
`else
    for (int c = 1; c < TMO + 16; c++) begin
      chk("wd_off_no_timeout", o_timeout, 0);
      chk("wd_off_busy", o_busy, 1);
      @(negedge i_clk);
    end
    run_access("wd_off", 1, cur);
    i_data_req = 1'b0;
`endif
    @(negedge i_clk);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
